vec_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the per-lane vector ALU. It processes `LANES` unsigned elements of `EW` bits per transfer under a per-lane mask, with a scalar constant operand. A two-stage registered pipeline with valid/ready handshakes on both sides replaces the single combinational path. It sits between the vector register read port and the vector writeback stage, and reports saturation events through a sticky counter.

---
 rtl/vec_alu_pipe.sv | 136 +++++++++++++
 tb/tb_vec_alu_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_pipe.sv
// Two-stage pipelined per-lane vector ALU with mask, scalar constant and valid/ready on both sides.
// Build macro VALU_SAT_EN: clamp ADD/ADDC/SUB and count saturated transfers; otherwise wrap, flag and count tie to 0.
module vec_alu_pipe #(
    parameter int LANES = 4,
    parameter int EW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic [LANES*EW-1:0] in_a,
    input  logic [LANES*EW-1:0] in_b,
    input  logic [EW-1:0]       c,
    input  logic [LANES-1:0]    mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*EW-1:0] out_data,
    output logic                sat_flag,
    input  logic                clr_cnt,
    output logic [15:0]         sat_count
);

    localparam int SHW = $clog2(EW);
`ifdef VALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                adv;
    logic                s1_valid;
    logic [2:0]          s1_op;
    logic [LANES*EW-1:0] s1_a;
    logic [LANES*EW-1:0] s1_b;
    logic [EW-1:0]       s1_c;
    logic [LANES-1:0]    s1_mask;
    logic [LANES*EW-1:0] res;
    logic                sat_any;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // Stage-1 payload needs no reset; only its valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_op   <= op;
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_c    <= c;
            s1_mask <= mask;
        end
    end

    always_comb begin
        logic [EW-1:0] a;
        logic [EW-1:0] b;
        logic [EW-1:0] r;
        logic [EW:0]   sum;
        logic [EW:0]   sumc;
        logic [EW:0]   dif;
        logic          s;
        res     = '0;
        sat_any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            a    = s1_a[i*EW +: EW];
            b    = s1_b[i*EW +: EW];
            sum  = {1'b0, a} + {1'b0, b};
            sumc = {1'b0, a} + {1'b0, s1_c};
            dif  = {1'b0, a} - {1'b0, b};
            r    = a;
            s    = 1'b0;
            case (s1_op)
                3'd0: r = a;
                3'd1: begin
                    s = SAT_EN && sum[EW];
                    r = s ? {EW{1'b1}} : sum[EW-1:0];
                end
                3'd2: begin
                    s = SAT_EN && dif[EW];
                    r = s ? {EW{1'b0}} : dif[EW-1:0];
                end
                3'd3: r = dif[EW] ? (b - a) : dif[EW-1:0];
                3'd4: r = (a >= s1_c) ? b : a;
                3'd5: begin
                    s = SAT_EN && sumc[EW];
                    r = s ? {EW{1'b1}} : sumc[EW-1:0];
                end
                3'd6: r = a >> s1_c[SHW-1:0];
                default: r = (a >= b) ? a : b;
            endcase
            if (s1_mask[i]) begin
                res[i*EW +: EW] = r;
                sat_any         = sat_any | s;
            end else begin
                res[i*EW +: EW] = a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res;
                sat_flag <= sat_any;
            end
        end
    end

`ifdef VALU_SAT_EN
    logic [15:0] cnt_q;

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && sat_flag && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign sat_count = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Directed bench for vec_alu_pipe (LANES=4, EW=8); expectations follow VALU_SAT_EN if defined.
module tb_vec_alu_pipe;

`ifdef VALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  c;
    logic [3:0]  mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        sat_flag;
    logic        clr_cnt;
    logic [15:0] sat_count;

    int n_cmp = 0;
    int n_err = 0;

    vec_alu_pipe #(.LANES(4), .EW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .c         (c),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .clr_cnt   (clr_cnt),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] v(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector for one edge, then let it reach stage 2.
    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] cc, input logic [3:0] m);
        op       = o;
        in_a     = a;
        in_b     = b;
        c        = cc;
        mask     = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_s1_only", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; in_a = '0; in_b = '0;
        c = '0; mask = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
        check("rst_sat_count", {16'd0, sat_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(3'd1, v(100, 200, 10, 0), v(103, 100, 5, 0), 8'd0, 4'b1111);
        check("add_data", out_data, SAT ? v(203, 255, 15, 0) : v(203, 44, 15, 0));
        check("add_sat", {31'd0, sat_flag}, {31'd0, SAT});
        tick();
        check("add_count", {16'd0, sat_count}, SAT ? 32'd1 : 32'd0);

        send(3'd2, v(100, 101, 5, 9), v(103, 1, 7, 2), 8'd0, 4'b0101);
        check("msub_data", out_data, SAT ? v(0, 101, 0, 9) : v(253, 101, 254, 9));
        check("msub_sat", {31'd0, sat_flag}, {31'd0, SAT});

        send(3'd4, v(20, 30, 25, 24), v(255, 255, 255, 255), 8'd25, 4'b1111);
        check("sel_data", out_data, v(20, 255, 255, 24));
        check("sel_sat", {31'd0, sat_flag}, 32'd0);
        check("count_after_sub", {16'd0, sat_count}, SAT ? 32'd2 : 32'd0);

        send(3'd6, v(100, 64, 255, 7), v(0, 0, 0, 0), 8'd9, 4'b1111);
        check("shr_data", out_data, v(50, 32, 127, 3));

        send(3'd3, v(10, 3, 200, 0), v(3, 10, 100, 0), 8'd0, 4'b1111);
        check("absdiff_data", out_data, v(7, 7, 100, 0));

        send(3'd7, v(1, 200, 50, 50), v(2, 100, 60, 50), 8'd0, 4'b1111);
        check("max_data", out_data, v(2, 200, 60, 50));

        send(3'd1, v(250, 250, 250, 250), v(10, 10, 10, 10), 8'd0, 4'b0000);
        check("mask0_data", out_data, v(250, 250, 250, 250));
        check("mask0_sat", {31'd0, sat_flag}, 32'd0);

        send(3'd5, v(250, 1, 0, 128), v(0, 0, 0, 0), 8'd10, 4'b1111);
        check("addc_data", out_data, SAT ? v(255, 11, 10, 138) : v(4, 11, 10, 138));
        check("addc_sat", {31'd0, sat_flag}, {31'd0, SAT});

        // Backpressure: three PASS vectors, consumer stalls four cycles.
        op = 3'd0; mask = 4'b1111; in_b = '0; c = '0;
        in_valid = 1'b1; in_a = v(1, 1, 1, 1);
        tick();
        check("bp_count", {16'd0, sat_count}, SAT ? 32'd3 : 32'd0);
        in_a = v(2, 2, 2, 2);
        tick();
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        check("bp_first_data", out_data, v(1, 1, 1, 1));
        out_ready = 1'b0;
        in_a = v(3, 3, 3, 3);
        #1;
        check("bp_in_ready_comb", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_hold_data", out_data, v(1, 1, 1, 1));
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_second", out_data, v(2, 2, 2, 2));
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_third", out_data, v(3, 3, 3, 3));
        check("bp_third_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with two saturating vectors in flight.
        op = 3'd1; in_a = v(255, 255, 255, 255); in_b = v(1, 1, 1, 1); mask = 4'b1111;
        in_valid = 1'b1;
        tick();
        tick();
        check("mid_full", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_count", {16'd0, sat_count}, 32'd0);
        tick();
        check("mid_no_emit", {31'd0, out_valid}, 32'd0);

        // Clear together with a saturating transfer.
        send(3'd1, v(255, 255, 255, 255), v(1, 1, 1, 1), 8'd0, 4'b1111);
        check("clr_sat_flag", {31'd0, sat_flag}, {31'd0, SAT});
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_wins", {16'd0, sat_count}, 32'd0);
        check("clr_transferred", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
